// File: rtl/aes_pkg.sv
// Shared definitions for the AES-CTR counter-block feeder: widths and FSM encoding.
package aes_pkg;

  localparam int NONCE_W = 96;
  localparam int CTR_W   = 32;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/aes_ctr_feeder_if.sv
// Output stream from the feeder to the dual-lane encrypt stage: block pair, lane-1 qualifier, key.
interface aes_ctr_feeder_if;
  import aes_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic               lane1_valid;
  logic [BLOCK_W-1:0] plaintext0;
  logic [BLOCK_W-1:0] plaintext1;
  logic [BLOCK_W-1:0] key_out;

  modport master (
    output out_valid, lane1_valid, plaintext0, plaintext1, key_out,
    input  out_ready
  );

  modport slave (
    input  out_valid, lane1_valid, plaintext0, plaintext1, key_out,
    output out_ready
  );

endinterface

// File: rtl/aes_ctr_inc.sv
// Counter/remaining-count datapath: holds the presented counter and blocks left, and
// produces the counter pair and lane-1 qualifier for the next presentation.
module aes_ctr_inc
  import aes_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [CTR_W-1:0] init_ctr,
  input  logic [CNT_W-1:0] num_blocks,
  output logic [CTR_W-1:0] nxt_ctr0,
  output logic [CTR_W-1:0] nxt_ctr1,
  output logic             nxt_lane1,
  output logic             last_pair
);

  logic [CTR_W-1:0] ctr_q;
  logic [CNT_W-1:0] rem_q;
  logic [CTR_W-1:0] ctr_base;
  logic [CNT_W-1:0] rem_base;

  function automatic logic [CNT_W-1:0] sat_sub2(input logic [CNT_W-1:0] v);
    return (v > CNT_W'(2)) ? v - CNT_W'(2) : '0;
  endfunction

  // Counter arithmetic wraps modulo 2^32; the nonce is never touched here.
  always_comb begin
    ctr_base  = load ? init_ctr : ctr_q + CTR_W'(2);
    rem_base  = load ? num_blocks : sat_sub2(rem_q);
    nxt_ctr0  = ctr_base;
    nxt_ctr1  = ctr_base + CTR_W'(1);
    nxt_lane1 = (rem_base >= CNT_W'(2));
    last_pair = (rem_q <= CNT_W'(2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q <= '0;
      rem_q <= '0;
    end else if (load || advance) begin
      ctr_q <= ctr_base;
      rem_q <= rem_base;
    end
  end

endmodule

// File: rtl/aes_ctr_feeder.sv
// AES-CTR counter-block feeder: emits {nonce, ctr}/{nonce, ctr+1} pairs to a dual-lane encryptor.
// Optional AES_CTR_KEY_LATCH_EN: key captured on accepted start instead of tracked every cycle.
module aes_ctr_feeder
  import aes_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   init_ctr,
  input  logic [CNT_W-1:0]   num_blocks,
  input  logic [BLOCK_W-1:0] key_in,
  output logic               busy,
  output logic               done,
  aes_ctr_feeder_if.master   m
);

  state_e             state;
  logic [NONCE_W-1:0] nonce_q;
  logic               out_valid_q;
  logic               lane1_valid_q;
  logic [BLOCK_W-1:0] plaintext0_q;
  logic [BLOCK_W-1:0] plaintext1_q;
  logic [BLOCK_W-1:0] key_q;

  logic               load;
  logic               advance;
  logic [CTR_W-1:0]   nxt_ctr0;
  logic [CTR_W-1:0]   nxt_ctr1;
  logic               nxt_lane1;
  logic               last_pair;

  assign load    = (state == IDLE) && start && (num_blocks != '0);
  assign advance = (state == RUN) && m.out_ready && !last_pair;

  aes_ctr_inc #(.CNT_W(CNT_W)) u_inc (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (advance),
    .init_ctr   (init_ctr),
    .num_blocks (num_blocks),
    .nxt_ctr0   (nxt_ctr0),
    .nxt_ctr1   (nxt_ctr1),
    .nxt_lane1  (nxt_lane1),
    .last_pair  (last_pair)
  );

  // out_ready is only ever sampled here, so nothing downstream sees a combinational path from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      nonce_q       <= '0;
      out_valid_q   <= 1'b0;
      lane1_valid_q <= 1'b0;
      plaintext0_q  <= '0;
      plaintext1_q  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (num_blocks != '0) begin
              state         <= RUN;
              nonce_q       <= nonce;
              out_valid_q   <= 1'b1;
              busy          <= 1'b1;
              plaintext0_q  <= {nonce, nxt_ctr0};
              plaintext1_q  <= {nonce, nxt_ctr1};
              lane1_valid_q <= nxt_lane1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (m.out_ready) begin
            if (last_pair) begin
              state       <= DONE;
              out_valid_q <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              plaintext0_q  <= {nonce_q, nxt_ctr0};
              plaintext1_q  <= {nonce_q, nxt_ctr1};
              lane1_valid_q <= nxt_lane1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_CTR_KEY_LATCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
    end else if ((state == IDLE) && start) begin
      key_q <= key_in;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
    end else begin
      key_q <= key_in;
    end
  end
`endif

  assign m.out_valid   = out_valid_q;
  assign m.lane1_valid = lane1_valid_q;
  assign m.plaintext0  = plaintext0_q;
  assign m.plaintext1  = plaintext1_q;
  assign m.key_out     = key_q;

endmodule
